// File: rtl/spi_reg_periph.sv
// SPI mode-0 peripheral fronting a bank of NUM_REGS configuration registers.
// Frame layout (MSB first): R/W (1 = write), ADDR_W address bits, DATA_W data bits.
// All SPI pins are oversampled in clk through synchronisers; frames of the wrong
// length or with an out-of-range write address are dropped with a frame_err pulse.
// An empty chip-select (nCS low then high with no SCLK rise) is ignored silently.
// Optional feature macro: SPI_PERIPH_READ_EN enables register read-back on CIPO.
module spi_reg_periph #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic                         CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME + 1);
`ifdef SPI_PERIPH_READ_EN
  localparam bit READ_EN = 1'b1;
  // bits already shifted in just before the final address bit arrives
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  // Bit counter advance that parks at FRAME+1 once a frame is overlong.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_p1, ncs_p1;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [FRAME-1:0]       sr, sr_nx;
  logic                   shift_en;
  logic                   frm_rw;
  logic [ADDR_W-1:0]      frm_addr;
  logic [DATA_W-1:0]      frm_data;
  logic                   addr_ok, commit_evt, write_ok, err_evt;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  // Synchronisers plus edge-detect flops; left unreset so a reset never fakes an edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
    copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
    ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
    sclk_p1   <= sclk_sync[SYNC_STAGES-1];
    ncs_p1    <= ncs_sync[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign ncs_rise  = ncs_s & ~ncs_p1;
  assign ncs_fall  = ~ncs_s & ncs_p1;

  assign sr_nx    = {sr[FRAME-2:0], copi_s};
  assign shift_en = (state == SHIFT) && sclk_rise && !ncs_rise;

  assign frm_rw     = sr[FRAME-1];
  assign frm_addr   = sr[FRAME-2 -: ADDR_W];
  assign frm_data   = sr[DATA_W-1:0];
  assign addr_ok    = ({1'b0, frm_addr} < (ADDR_W+1)'(NUM_REGS));
  assign commit_evt = (state == FULL) && ncs_rise;
  assign write_ok   = commit_evt && frm_rw && addr_ok;
  assign err_evt    = ncs_rise && (((state == SHIFT) && (cnt != '0)) || (state == OVER) ||
                      ((state == FULL) && !addr_ok && (frm_rw || READ_EN)));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state; an nCS rise always beats a coincident SCLK rise.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ncs_fall) state_nx = SHIFT;
      SHIFT: if (ncs_rise) state_nx = IDLE;
             else if (sclk_rise && cnt == CNT_LAST) state_nx = FULL;
      FULL:  if (ncs_rise) state_nx = IDLE;
             else if (sclk_rise) state_nx = OVER;
      OVER:  if (ncs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit counter; a frame start clears it even if SCLK rises in the same clk.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   cnt <= '0;
    else if ((state == IDLE) && ncs_fall)         cnt <= '0;
    else if (sclk_rise && !ncs_rise && (state != IDLE)) cnt <= cnt_sat_inc(cnt);
  end

  // Frame shift register (data only, no reset).
  always_ff @(posedge clk) begin
    if (shift_en) sr <= sr_nx;
  end

  // Register bank commit, write strobe and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= write_ok;
      frame_err <= err_evt;
      if (write_ok) begin
        wr_addr <= frm_addr;
        for (int i = 0; i < NUM_REGS; i++)
          if (frm_addr == ADDR_W'(i)) regs[i] <= frm_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

`ifdef SPI_PERIPH_READ_EN
  logic [DATA_W-1:0] shadow, rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_armed, rd_load;

  assign rd_addr = sr_nx[ADDR_W-1:0];
  assign rd_load = shift_en && (cnt == CNT_ADDR) && !sr_nx[ADDR_W];

  // Read mux; an address with no register reads back as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_sel = regs[i];
  end

  // Shadow capture after the last address bit, then shift out on each SCLK fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_armed <= 1'b0;
      CIPO     <= 1'b0;
      CIPO_oe  <= 1'b0;
    end else if (ncs_rise || (state == IDLE)) begin
      rd_armed <= 1'b0;
      CIPO     <= 1'b0;
      CIPO_oe  <= 1'b0;
    end else if (rd_load) begin
      shadow   <= rd_sel;
      rd_armed <= 1'b1;
    end else if (sclk_fall && rd_armed) begin
      CIPO    <= shadow[DATA_W-1];
      shadow  <= shadow << 1;
      CIPO_oe <= 1'b1;
    end
  end
`else
  assign CIPO    = 1'b0;
  assign CIPO_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_periph.sv
// Self-checking bench for spi_reg_periph: directed scenarios plus randomized frames,
// with a frame-level reference model of the register bank and its output pulses.
`timescale 1ns/1ps
module tb_spi_reg_periph;
  localparam int NR = 5, DW = 8, AW = 7, S = 2;
  localparam int FRAME  = 1 + AW + DW;
  localparam int DSTART = 1 + AW;
`ifdef SPI_PERIPH_READ_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, SCLK, COPI, nCS;
  logic CIPO, CIPO_oe, wr_strobe, frame_err;
  logic [NR*DW-1:0] regs_flat;
  logic [AW-1:0] wr_addr;

  spi_reg_periph #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .CIPO(CIPO), .CIPO_oe(CIPO_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit chk_on = 0, in_read = 0, cipo_chk = 0;
  logic cipo_exp = 1'b0;
  logic [NR*DW-1:0] m_flat = '0, bank_now = '0, bank_next = '0;
  int bank_at = 0;
  logic [AW-1:0] addr_now = '0, addr_next = '0;
  int addr_at = 0;
  int strobe_at = -1, err_at = -1;
  int strobe_seen = 0, err_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle after reset, DUT outputs versus the model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_on) begin
        chk("regs_flat", regs_flat, (cyc >= bank_at) ? bank_next : bank_now);
        chk("wr_strobe", wr_strobe, cyc == strobe_at);
        chk("frame_err", frame_err, cyc == err_at);
        chk("wr_addr", wr_addr, (cyc >= addr_at) ? addr_next : addr_now);
        if (cipo_chk) begin
          chk("CIPO_data", CIPO, cipo_exp);
          chk("CIPO_oe_data", CIPO_oe, 1'b1);
        end else if (!in_read) begin
          chk("CIPO_idle", CIPO, 1'b0);
          chk("CIPO_oe_idle", CIPO_oe, 1'b0);
        end
        if (wr_strobe) strobe_seen++;
        if (frame_err) err_seen++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bank(input logic [NR*DW-1:0] nb, input int t);
    bank_now = bank_next; bank_next = nb; bank_at = t;
  endtask

  task automatic set_addr(input logic [AW-1:0] na, input int t);
    addr_now = addr_next; addr_next = na; addr_at = t;
  endtask

  task automatic send_bit(input logic b, input int half, input bit chk_en,
                          input logic expb, output logic seen);
    COPI = b;
    wait_clks(half);
    SCLK = 1'b1;
    seen = CIPO;
    cipo_exp = expb;
    cipo_chk = chk_en;
    wait_clks(half);
    SCLK = 1'b0;
    cipo_chk = 1'b0;
  endtask

  // Drive one chip-select window of nbits bits (v[nbits-1] first) and predict its outcome.
  task automatic send_frame(input logic [63:0] v, input int nbits, input int half,
                            input bit simul_start, input bit simul_end,
                            output logic [DW-1:0] cap);
    logic rw, sb, eb;
    logic [AW-1:0] a;
    logic [DW-1:0] rdv;
    bit dbit;
    int t, idx;
    rw = (nbits > 0) ? v[nbits-1] : 1'b1;
    a = '0;
    rdv = '0;
    if (nbits >= DSTART) begin
      a = v[nbits-2 -: AW];
      if (!rw && a < NR) rdv = m_flat[a*DW +: DW];
    end
    cap = '0;
    in_read = RD && (nbits > 0) && !rw;
    nCS = 1'b0;
    if (simul_start) SCLK = 1'b1;
    wait_clks(half);
    if (simul_start) SCLK = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      dbit = (i >= DSTART) && (i < FRAME);
      idx = dbit ? (FRAME - 1 - i) : 0;
      eb = rdv[idx];
      send_bit(v[nbits-1-i], half, RD && !rw && dbit, eb, sb);
      if (dbit) cap[idx] = sb;
    end
    wait_clks(half);
    nCS = 1'b1;
    if (simul_end) SCLK = 1'b1;
    t = cyc + S + 1;
    if (nbits == 0) begin
      // empty select: nothing happens
    end else if (nbits != FRAME) begin
      err_at = t;
    end else if (rw) begin
      if (a < NR) begin
        m_flat[a*DW +: DW] = v[DW-1:0];
        set_bank(m_flat, t);
        set_addr(a, t);
        strobe_at = t;
      end else begin
        err_at = t;
      end
    end else if (RD && a >= NR) begin
      err_at = t;
    end
    wait_clks(half);
    SCLK = 1'b0;
    wait_clks(S + 6);
    in_read = 1'b0;
  endtask

  task automatic sclk_idle_toggles(input int n);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1; wait_clks(5);
      SCLK = 1'b0; wait_clks(5);
    end
  endtask

  initial begin
    logic [DW-1:0] cap;
    logic [63:0] v;
    logic sb;
    int s0, e0, nb, hf;
    rst_n = 1'b0; nCS = 1'b1; SCLK = 1'b0; COPI = 1'b0;
    wait_clks(6);
    rst_n = 1'b1;
    chk_on = 1'b1;
    chk("reset_regs", regs_flat, '0);
    chk("reset_wr_addr", wr_addr, '0);
    chk("reset_pulses", {wr_strobe, frame_err, CIPO, CIPO_oe}, 4'b0);
    wait_clks(4);

    // 1: write reg2 = 0xA5
    s0 = strobe_seen; e0 = err_seen;
    send_frame(64'h82A5, 16, 8, 0, 0, cap);
    chk("t1_regs", regs_flat, 40'h00_00_A5_00_00);
    chk("t1_strobes", strobe_seen - s0, 1);
    chk("t1_wr_addr", wr_addr, 7'd2);

    // 2: write to nonexistent address 7
    s0 = strobe_seen; e0 = err_seen;
    send_frame(64'h87FF, 16, 8, 0, 0, cap);
    chk("t2_regs", regs_flat, 40'h00_00_A5_00_00);
    chk("t2_err", err_seen - e0, 1);
    chk("t2_strobes", strobe_seen - s0, 0);

    // 3: short (10-bit) and long (18-bit) frames
    e0 = err_seen;
    send_frame(64'h813C >> 6, 10, 8, 0, 0, cap);
    send_frame({46'd0, 16'h813C, 2'b11}, 18, 8, 0, 0, cap);
    chk("t3_err", err_seen - e0, 2);
    chk("t3_reg1", regs_flat[15:8], 8'h00);

    // 4: reset in the middle of a write frame
    s0 = strobe_seen; e0 = err_seen;
    v = 64'h8055;
    nCS = 1'b0;
    wait_clks(8);
    for (int i = 0; i < 8; i++) send_bit(v[15-i], 8, 0, 1'b0, sb);
    rst_n = 1'b0;
    m_flat = '0;
    set_bank('0, cyc + 1);
    set_addr('0, cyc + 1);
    wait_clks(4);
    chk("t4_reset_regs", regs_flat, '0);
    rst_n = 1'b1;
    wait_clks(8);
    nCS = 1'b1;
    wait_clks(12);
    chk("t4_no_pulses", (strobe_seen - s0) + (err_seen - e0), 0);
    send_frame(64'h8055, 16, 8, 0, 0, cap);
    chk("t4_reg0", regs_flat, 40'h00_00_00_00_55);

    // 5: write reg4 = 0x3C, then read it back
    send_frame(64'h843C, 16, 8, 0, 0, cap);
    send_frame(64'h04A7, 16, 8, 0, 0, cap);
    chk("t5_read_cipo", cap, RD ? 8'h3C : 8'h00);
    chk("t5_reg4", regs_flat[39:32], 8'h3C);

    // 6: nCS toggled without SCLK, SCLK toggled with nCS high
    s0 = strobe_seen; e0 = err_seen;
    send_frame(64'h0, 0, 8, 0, 0, cap);
    sclk_idle_toggles(6);
    wait_clks(8);
    chk("t6_no_pulses", (strobe_seen - s0) + (err_seen - e0), 0);
    chk("t6_regs", regs_flat, 40'h3C_00_00_00_55);

    // 7: SCLK rise coincident with nCS fall and with nCS rise
    s0 = strobe_seen;
    send_frame(64'h8199, 16, 6, 1, 1, cap);
    chk("t7_regs", regs_flat, 40'h3C_00_00_99_55);
    chk("t7_strobes", strobe_seen - s0, 1);

    // 8: randomized frames
    for (int k = 0; k < 60; k++) begin
      v = {$urandom, $urandom};
      nb = FRAME;
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(0, FRAME + 3);
      else if ($urandom_range(0, 3) != 0) v[FRAME-2 -: AW] = 7'($urandom_range(0, 7));
      hf = $urandom_range(4, 9);
      send_frame(v, nb, hf, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, cap);
      if ($urandom_range(0, 7) == 0) sclk_idle_toggles(2);
      wait_clks($urandom_range(0, 6));
    end
    wait_clks(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
